// File: rtl/segment_read_agu.sv
// Segment-relative read address unit: latches segment:offset, forms the
// 20-bit physical address and runs one T1..T4 memory read bus cycle.
module segment_read_agu #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_seg,
    input  logic [15:0] req_off,
    input  logic [15:0] cs_in,
    input  logic [15:0] ds_in,
    input  logic [15:0] ss_in,
    input  logic [15:0] es_in,
    output logic [19:0] bus_addr,
    output logic        bus_ale,
    output logic        bus_rd_n,
    input  logic        bus_ready,
    input  logic [15:0] bus_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [19:0] rsp_addr,
    output logic        rsp_err
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        T4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [15:0]     seg_sel;
    logic [19:0]     phys;
    logic            accept;
    logic            last_wait;

    always_comb begin
        seg_sel = cs_in;
        unique case (req_seg)
            2'b00:   seg_sel = cs_in;
            2'b01:   seg_sel = ds_in;
            2'b10:   seg_sel = ss_in;
            default: seg_sel = es_in;
        endcase
    end

    // Carry out of bit 19 falls off the 20-bit sum.
    assign phys      = {seg_sel, 4'h0} + {4'h0, req_off};
    assign accept    = req_valid && (state == IDLE);
    assign last_wait = (cnt == CW'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        bus_ale   = 1'b0;
        bus_rd_n  = 1'b1;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = T1;
            end
            T1: begin
                bus_ale  = 1'b1;
                state_nx = T2;
            end
            T2: begin
                bus_rd_n = 1'b0;
                state_nx = T3;
            end
            T3: begin
                bus_rd_n = 1'b0;
                if (bus_ready || last_wait) state_nx = T4;
            end
            T4: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // bus_addr doubles as the latched physical address of the cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_addr <= '0;
            rsp_data <= '0;
            rsp_addr <= '0;
            rsp_err  <= 1'b0;
            cnt      <= '0;
        end else begin
            if (accept) bus_addr <= phys;
            if (state == T3) begin
                if (bus_ready) begin
                    rsp_data <= bus_data;
                    rsp_addr <= bus_addr;
                    rsp_err  <= 1'b0;
                    cnt      <= '0;
                end else if (last_wait) begin
                    rsp_data <= '0;
                    rsp_addr <= bus_addr;
                    rsp_err  <= 1'b1;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (state == T4) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_segment_read_agu.sv
// Scoreboard bench for segment_read_agu: directed requests push expected
// responses; a negedge monitor pops and compares on rsp_valid.
module tb_segment_read_agu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_seg = 2'b00;
    logic [15:0] req_off = 16'h0;
    logic [15:0] cs_in = 16'h0;
    logic [15:0] ds_in = 16'h0;
    logic [15:0] ss_in = 16'h0;
    logic [15:0] es_in = 16'h0;
    logic [19:0] bus_addr;
    logic        bus_ale;
    logic        bus_rd_n;
    logic        bus_ready = 1'b0;
    logic [15:0] bus_data = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [19:0] rsp_addr;
    logic        rsp_err;

    segment_read_agu #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_seg(req_seg), .req_off(req_off),
        .cs_in(cs_in), .ds_in(ds_in), .ss_in(ss_in), .es_in(es_in),
        .bus_addr(bus_addr), .bus_ale(bus_ale), .bus_rd_n(bus_rd_n),
        .bus_ready(bus_ready), .bus_data(bus_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   wait_n = 0;
    int   lowcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: T2 is the first rd_n-low cycle, T3 follows.
    always @(negedge clk) begin
        if (!bus_rd_n) begin
            lowcnt = lowcnt + 1;
            bus_ready = (lowcnt >= 2) && ((lowcnt - 2) >= wait_n);
        end else begin
            lowcnt = 0;
            bus_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst && bus_ale && q.size() > 0)
            check("t1_bus_addr", {12'h0, bus_addr}, {12'h0, q[0].addr});
        if (rst && rsp_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_addr", {12'h0, rsp_addr}, {12'h0, e.addr});
                check("rsp_data", {16'h0, rsp_data}, {16'h0, e.data});
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                check("rsp_latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic issue(input logic [1:0] seg, input logic [15:0] off,
                         input int wn, input logic [15:0] data,
                         input logic [19:0] ea, input logic [15:0] ed,
                         input logic ee, input int lat, input bit push,
                         input bit ss_wr, input logic [15:0] ss_new);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_seg   = seg;
        req_off   = off;
        wait_n    = wn;
        bus_data  = data;
        check("req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        if (ss_wr) ss_in <= ss_new;
        #1;
        req_valid = 1'b0;
        e.addr = ea;
        e.data = ed;
        e.err  = ee;
        e.lat  = lat;
        e.acc  = cyc;
        if (push) q.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 60) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_timeout: got no rsp expected %0d", q.size());
            q.delete();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_bus_addr", {12'h0, bus_addr}, 32'h0);
        check("rst_bus_ale", {31'h0, bus_ale}, 32'h0);
        check("rst_bus_rd_n", {31'h0, bus_rd_n}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
        check("rst_rsp_addr", {12'h0, rsp_addr}, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);
        rst   = 1'b1;
        cs_in = 16'h1234;
        ds_in = 16'h2000;
        ss_in = 16'h0100;
        es_in = 16'hFFFF;

        issue(2'b00, 16'h0010, 0, 16'h1111, 20'h12350, 16'h1111,
              1'b0, 4, 1, 0, 16'h0);
        drain();
        issue(2'b11, 16'hFFFF, 0, 16'h2222, 20'h0FFEF, 16'h2222,
              1'b0, 4, 1, 0, 16'h0);
        drain();
        issue(2'b01, 16'h0004, 3, 16'hBEEF, 20'h20004, 16'hBEEF,
              1'b0, 7, 1, 0, 16'h0);
        drain();
        issue(2'b01, 16'h0100, 100, 16'hDEAD, 20'h20100, 16'h0000,
              1'b1, 18, 1, 0, 16'h0);
        drain();
        issue(2'b10, 16'h0000, 1, 16'h3333, 20'h01000, 16'h3333,
              1'b0, 5, 1, 1, 16'h0200);
        drain();
        issue(2'b10, 16'h0000, 0, 16'h4444, 20'h02000, 16'h4444,
              1'b0, 4, 1, 0, 16'h0);
        drain();

        issue(2'b00, 16'h0000, 100, 16'h5555, 20'h12340, 16'h0,
              1'b0, 0, 0, 0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_rd_n", {31'h0, bus_rd_n}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        check("midrst_rd_n", {31'h0, bus_rd_n}, 32'h1);
        check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);

        issue(2'b01, 16'hFFFF, 2, 16'hA5A5, 20'h2FFFF, 16'hA5A5,
              1'b0, 6, 1, 0, 16'h0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("hold_rsp_data", {16'h0, rsp_data}, 32'hA5A5);
        check("hold_rsp_addr", {12'h0, rsp_addr}, 32'h2FFFF);
        check("idle_bus_addr", {12'h0, bus_addr}, 32'h2FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
